// File: rtl/ritc_datapath_align.sv
// RITC deserializer alignment: sample-major reorder of the deserialized words plus a
// per-lane bitslip training FSM that walks every lane until it sees the training word.
module ritc_datapath_align #(
  parameter int NCH = 6,
  parameter int NBITS = 12,
  parameter int DEMUX = 4,
  parameter logic [DEMUX-1:0] TRAIN_PAT = 4'b0011,
  parameter int SETTLE = 4,
  parameter int MATCH_CNT = 8,
  parameter int MAX_SLIPS = 2 * DEMUX
) (
  input  logic                         SYSCLK,
  input  logic                         rst_i,
  input  logic [NCH*NBITS*DEMUX-1:0]   data_i,
  input  logic                         data_valid_i,
  input  logic                         train_start_i,
  output logic [NCH*NBITS*DEMUX-1:0]   data_o,
  output logic                         data_valid_o,
  output logic [NCH*NBITS-1:0]         bitslip_o,
  output logic                         busy_o,
  output logic                         done_o,
  output logic [NCH*NBITS-1:0]         fail_o
);

  localparam int LANES  = NCH * NBITS;
  localparam int W      = LANES * DEMUX;
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int SLIP_W = $clog2(MAX_SLIPS + 1);
  localparam int SET_W  = $clog2(SETTLE + 1);
  localparam int MCH_W  = $clog2(MATCH_CNT + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CHECK,
    ST_SLIP,
    ST_NEXT,
    ST_DONE
  } state_t;

  state_t              state;
  logic [LANE_W-1:0]   lane;
  logic [SLIP_W-1:0]   slip_cnt;
  logic [SET_W-1:0]    settle_cnt;
  logic [MCH_W-1:0]    match_cnt;

  logic [W-1:0]        reorder;
  logic [DEMUX-1:0]    lane_word;
  logic [LANES-1:0]    lane_hot;

  // Lane-major (per serial lane) to sample-major (per channel, per time slot) bit shuffle
  always_comb begin
    reorder = '0;
    for (int c = 0; c < NCH; c++)
      for (int k = 0; k < DEMUX; k++)
        for (int j = 0; j < NBITS; j++)
          reorder[c*NBITS*DEMUX + k*NBITS + j] = data_i[(c*NBITS + j)*DEMUX + k];
  end

  always_ff @(posedge SYSCLK or posedge rst_i) begin
    if (rst_i) begin
      data_o       <= '0;
      data_valid_o <= 1'b0;
    end else begin
      data_o       <= reorder;
      data_valid_o <= data_valid_i;
    end
  end

  always_comb begin
    lane_word = '0;
    lane_hot  = '0;
    for (int l = 0; l < LANES; l++) begin
      if (lane == LANE_W'(l)) begin
        lane_word   = data_i[l*DEMUX +: DEMUX];
        lane_hot[l] = 1'b1;
      end
    end
  end

  // Training sequencer; bitslip_o is a one-cycle pulse emitted on the SLIP->SETTLE edge
  always_ff @(posedge SYSCLK or posedge rst_i) begin
    if (rst_i) begin
      state      <= ST_IDLE;
      lane       <= '0;
      slip_cnt   <= '0;
      settle_cnt <= '0;
      match_cnt  <= '0;
      bitslip_o  <= '0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      fail_o     <= '0;
    end else begin
      bitslip_o <= '0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (train_start_i) begin
            fail_o     <= '0;
            done_o     <= 1'b0;
            busy_o     <= 1'b1;
            lane       <= '0;
            slip_cnt   <= '0;
            settle_cnt <= '0;
            state      <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (data_valid_i) begin
            if (settle_cnt == SET_W'(SETTLE - 1)) begin
              settle_cnt <= '0;
              match_cnt  <= '0;
              state      <= ST_CHECK;
            end else begin
              settle_cnt <= settle_cnt + SET_W'(1);
            end
          end
        end
        ST_CHECK: begin
          if (data_valid_i) begin
            if (lane_word == TRAIN_PAT) begin
              match_cnt <= match_cnt + MCH_W'(1);
              if (match_cnt == MCH_W'(MATCH_CNT - 1)) state <= ST_NEXT;
            end else begin
              state <= ST_SLIP;
            end
          end
        end
        ST_SLIP: begin
          if (slip_cnt == SLIP_W'(MAX_SLIPS)) begin
            fail_o <= fail_o | lane_hot;
            state  <= ST_NEXT;
          end else begin
            bitslip_o  <= lane_hot;
            slip_cnt   <= slip_cnt + SLIP_W'(1);
            settle_cnt <= '0;
            state      <= ST_SETTLE;
          end
        end
        ST_NEXT: begin
          if (lane == LANE_W'(LANES - 1)) begin
            busy_o <= 1'b0;
            done_o <= 1'b1;
            state  <= ST_DONE;
          end else begin
            lane       <= lane + LANE_W'(1);
            slip_cnt   <= '0;
            settle_cnt <= '0;
            state      <= ST_SETTLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ritc_datapath_align.sv
// Bench for ritc_datapath_align: reorder mapping plus lane training against a
// lane model whose words rotate every time the DUT pulses that lane's bitslip.
module tb_ritc_datapath_align;

  localparam int NCH = 6;
  localparam int NBITS = 12;
  localparam int DEMUX = 4;
  localparam logic [DEMUX-1:0] TRAIN_PAT = 4'b0011;
  localparam int SETTLE = 4;
  localparam int MATCH_CNT = 8;
  localparam int MAX_SLIPS = 2 * DEMUX;
  localparam int LANES = NCH * NBITS;
  localparam int W = LANES * DEMUX;
  localparam int LIMIT = 20000;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [W-1:0]     data_i = '0;
  logic             data_valid_i = 1'b0;
  logic             train_start = 1'b0;
  logic [W-1:0]     data_o;
  logic             data_valid_o;
  logic [LANES-1:0] bitslip_o;
  logic             busy_o;
  logic             done_o;
  logic [LANES-1:0] fail_o;

  ritc_datapath_align dut (
    .SYSCLK(clk), .rst_i(rst), .data_i(data_i), .data_valid_i(data_valid_i),
    .train_start_i(train_start), .data_o(data_o), .data_valid_o(data_valid_o),
    .bitslip_o(bitslip_o), .busy_o(busy_o), .done_o(done_o), .fail_o(fail_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Lane model: rotation offset still to be undone by slips, or stuck at all-ones
  int               off[LANES];
  bit               stuck[LANES];
  int               pulses[LANES];
  int               exp_p[LANES];
  logic [LANES-1:0] exp_f;
  int               first_pulse;
  int               multi_hot;
  int               cycles;
  bit               got_done;
  logic             busy_s, done_s;
  logic [LANES-1:0] fail_s;

  function automatic logic [DEMUX-1:0] rot(input logic [DEMUX-1:0] p, input int r);
    logic [DEMUX-1:0] q;
    q = p;
    for (int i = 0; i < r; i++) q = {q[0], q[DEMUX-1:1]};
    return q;
  endfunction

  function automatic logic [W-1:0] model_word();
    logic [W-1:0] w;
    w = '0;
    for (int l = 0; l < LANES; l++)
      w[l*DEMUX +: DEMUX] = stuck[l] ? {DEMUX{1'b1}} : rot(TRAIN_PAT, off[l]);
    return w;
  endfunction

  function automatic logic [W-1:0] rnd_word();
    logic [W-1:0] w;
    w = '0;
    for (int l = 0; l < LANES; l++) w[l*DEMUX +: DEMUX] = DEMUX'($urandom);
    return w;
  endfunction

  task automatic clear_cfg();
    for (int l = 0; l < LANES; l++) begin
      off[l] = 0;
      stuck[l] = 1'b0;
    end
  endtask

  task automatic set_expect();
    for (int l = 0; l < LANES; l++) begin
      exp_p[l] = stuck[l] ? MAX_SLIPS : off[l];
      exp_f[l] = stuck[l];
    end
  endtask

  task automatic step(input bit v, input bit st);
    @(negedge clk);
    train_start  = st;
    data_valid_i = v;
    data_i       = v ? model_word() : rnd_word();
    @(posedge clk);
    #1;
    if ($countones(bitslip_o) > 1) multi_hot++;
    for (int l = 0; l < LANES; l++) begin
      if (bitslip_o[l] === 1'b1) begin
        pulses[l]++;
        off[l] = (off[l] + DEMUX - 1) % DEMUX;
        if (first_pulse < 0) first_pulse = l;
      end
    end
  endtask

  task automatic train_run(input int pct, input int restart_lane, input int abort_lane);
    bit v, st, sent;
    for (int l = 0; l < LANES; l++) pulses[l] = 0;
    multi_hot = 0;
    first_pulse = -1;
    cycles = 0;
    got_done = 1'b0;
    sent = 1'b0;
    step(1'b1, 1'b1);
    busy_s = busy_o;
    done_s = done_o;
    fail_s = fail_o;
    while (cycles < LIMIT) begin
      v = (pct >= 100) ? 1'b1 : ($urandom_range(99) < pct);
      st = 1'b0;
      if (restart_lane >= 0 && !sent && pulses[restart_lane] > 0) begin
        st = 1'b1;
        sent = 1'b1;
      end
      step(v, st);
      cycles++;
      if (done_o === 1'b1) begin
        got_done = 1'b1;
        break;
      end
      if (abort_lane >= 0 && bitslip_o[abort_lane] === 1'b1) break;
    end
    train_start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    data_valid_i = 1'b1;
    data_i = rnd_word();
    train_start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({data_valid_o, busy_o, done_o} !== 3'b000) begin
      n_err++;
      $display("FAIL reset_ctrl: got valid/busy/done=%b required 000", {data_valid_o, busy_o, done_o});
    end
    n_cmp++;
    if (data_o !== '0) begin
      n_err++;
      $display("FAIL reset_data: got %h required 0", data_o);
    end
    n_cmp++;
    if ({bitslip_o, fail_o} !== '0) begin
      n_err++;
      $display("FAIL reset_lanes: got bitslip=%h fail=%h required 0", bitslip_o, fail_o);
    end
    @(negedge clk);
    train_start = 1'b0;
    data_valid_i = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_reorder();
    logic [W-1:0] din, exp;
    logic [3:0] got4;
    logic v;
    @(negedge clk);
    din = '0;
    din[3:0] = 4'b1010;
    data_i = din;
    data_valid_i = 1'b1;
    @(posedge clk);
    #1;
    got4 = {data_o[36], data_o[24], data_o[12], data_o[0]};
    n_cmp++;
    if (got4 !== 4'b1010 || data_valid_o !== 1'b1) begin
      n_err++;
      $display("FAIL reorder_lane00: got k3..k0=%b valid=%b required 1010 valid=1", got4, data_valid_o);
    end
    for (int t = 0; t < 16; t++) begin
      @(negedge clk);
      din = rnd_word();
      v = 1'(t % 3 != 1);
      data_i = din;
      data_valid_i = v;
      exp = '0;
      for (int c = 0; c < NCH; c++)
        for (int k = 0; k < DEMUX; k++)
          for (int j = 0; j < NBITS; j++)
            exp[c*NBITS*DEMUX + k*NBITS + j] = din[(c*NBITS + j)*DEMUX + k];
      @(posedge clk);
      #1;
      n_cmp++;
      if (data_o !== exp || data_valid_o !== v) begin
        n_err++;
        $display("FAIL reorder_rand%0d: got %h/%b required %h/%b", t, data_o, data_valid_o, exp, v);
      end
    end
  endtask

  task automatic test_all_aligned();
    clear_cfg();
    set_expect();
    train_run(100, -1, -1);
    n_cmp++;
    if (busy_s !== 1'b1 || done_s !== 1'b0) begin
      n_err++;
      $display("FAIL aligned_start: got busy=%b done=%b required busy=1 done=0", busy_s, done_s);
    end
    n_cmp++;
    if (!got_done || cycles != LANES * (SETTLE + MATCH_CNT) + LANES) begin
      n_err++;
      $display("FAIL aligned_duration: got done=%0d cycles=%0d required done=1 cycles=%0d",
               got_done, cycles, LANES * (SETTLE + MATCH_CNT) + LANES);
    end
    for (int l = 0; l < LANES; l++) begin
      n_cmp++;
      if (pulses[l] != exp_p[l]) begin
        n_err++;
        $display("FAIL aligned_pulses lane %0d: got %0d required %0d", l, pulses[l], exp_p[l]);
      end
    end
    n_cmp++;
    if (fail_o !== exp_f || busy_o !== 1'b0) begin
      n_err++;
      $display("FAIL aligned_result: got fail=%h busy=%b required fail=%h busy=0", fail_o, busy_o, exp_f);
    end
    repeat (5) step(1'b1, 1'b0);
    n_cmp++;
    if (done_o !== 1'b1 || busy_o !== 1'b0 || bitslip_o !== '0) begin
      n_err++;
      $display("FAIL done_hold: got done=%b busy=%b bitslip=%h required done=1 busy=0 bitslip=0",
               done_o, busy_o, bitslip_o);
    end
  endtask

  task automatic test_stuck_lane();
    clear_cfg();
    stuck[17] = 1'b1;
    set_expect();
    train_run(100, -1, -1);
    n_cmp++;
    if (!got_done || multi_hot != 0) begin
      n_err++;
      $display("FAIL stuck_done: got done=%0d multi_hot=%0d required 1 and 0", got_done, multi_hot);
    end
    for (int l = 0; l < LANES; l++) begin
      n_cmp++;
      if (pulses[l] != exp_p[l]) begin
        n_err++;
        $display("FAIL stuck_pulses lane %0d: got %0d required %0d", l, pulses[l], exp_p[l]);
      end
    end
    n_cmp++;
    if (fail_o !== exp_f) begin
      n_err++;
      $display("FAIL stuck_fail: got %h required %h", fail_o, exp_f);
    end
  endtask

  task automatic test_rotated_lane();
    clear_cfg();
    off[5] = 2;
    set_expect();
    train_run(100, -1, -1);
    n_cmp++;
    if (fail_s !== '0 || done_s !== 1'b0) begin
      n_err++;
      $display("FAIL restart_clears: got fail=%h done=%b required 0 and 0", fail_s, done_s);
    end
    n_cmp++;
    if (!got_done || multi_hot != 0) begin
      n_err++;
      $display("FAIL rotated_done: got done=%0d multi_hot=%0d required 1 and 0", got_done, multi_hot);
    end
    for (int l = 0; l < LANES; l++) begin
      n_cmp++;
      if (pulses[l] != exp_p[l]) begin
        n_err++;
        $display("FAIL rotated_pulses lane %0d: got %0d required %0d", l, pulses[l], exp_p[l]);
      end
    end
    n_cmp++;
    if (fail_o !== exp_f) begin
      n_err++;
      $display("FAIL rotated_fail: got %h required %h", fail_o, exp_f);
    end
  endtask

  task automatic test_gapped_valid_busy_start();
    clear_cfg();
    stuck[2] = 1'b1;
    off[5] = 2;
    stuck[17] = 1'b1;
    off[40] = 3;
    set_expect();
    train_run(50, 5, -1);
    n_cmp++;
    if (!got_done || multi_hot != 0) begin
      n_err++;
      $display("FAIL gapped_done: got done=%0d multi_hot=%0d required 1 and 0", got_done, multi_hot);
    end
    for (int l = 0; l < LANES; l++) begin
      n_cmp++;
      if (pulses[l] != exp_p[l]) begin
        n_err++;
        $display("FAIL gapped_pulses lane %0d: got %0d required %0d", l, pulses[l], exp_p[l]);
      end
    end
    n_cmp++;
    if (fail_o !== exp_f) begin
      n_err++;
      $display("FAIL gapped_fail: got %h required %h", fail_o, exp_f);
    end
  endtask

  task automatic test_reset_mid_training();
    clear_cfg();
    stuck[10] = 1'b1;
    off[30] = 1;
    train_run(100, -1, 30);
    n_cmp++;
    if (got_done || pulses[30] != 1 || fail_o[10] !== 1'b1) begin
      n_err++;
      $display("FAIL midreset_setup: got done=%0d pulses30=%0d fail10=%b required 0, 1, 1",
               got_done, pulses[30], fail_o[10]);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({busy_o, done_o, data_valid_o} !== 3'b000 || bitslip_o !== '0 || fail_o !== '0 || data_o !== '0) begin
      n_err++;
      $display("FAIL midreset_outputs: got busy=%b done=%b bitslip=%h fail=%h required all 0",
               busy_o, done_o, bitslip_o, fail_o);
    end
    #2;
    rst = 1'b0;
    clear_cfg();
    off[0] = 1;
    set_expect();
    train_run(100, -1, -1);
    n_cmp++;
    if (busy_s !== 1'b1 || first_pulse != 0) begin
      n_err++;
      $display("FAIL midreset_restart: got busy=%b first_pulse_lane=%0d required 1 and 0", busy_s, first_pulse);
    end
    n_cmp++;
    if (!got_done || fail_o !== exp_f) begin
      n_err++;
      $display("FAIL midreset_result: got done=%0d fail=%h required 1 and %h", got_done, fail_o, exp_f);
    end
    for (int l = 0; l < LANES; l++) begin
      n_cmp++;
      if (pulses[l] != exp_p[l]) begin
        n_err++;
        $display("FAIL midreset_pulses lane %0d: got %0d required %0d", l, pulses[l], exp_p[l]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_reorder();
    test_all_aligned();
    test_stuck_lane();
    test_rotated_lane();
    test_gapped_valid_busy_start();
    test_reset_mid_training();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
